// File: rtl/wb_spi_slave.sv
// rtl/wb_spi_slave.sv - Wishbone classic slave front end for the SPI interface core
//
// Purpose: turns Wishbone classic cycles into single-cycle cmd/wr/rd strobes
// towards the SPI core, waits for the core ack and completes the bus cycle.
// Keeps a readback copy of the last accepted config word and two saturating
// diagnostic counters (timeouts, empty rx reads).
//
// Register map (wb_adr_i):
//   0 DATA   write -> if_wr, read -> if_rd, returns {0, if_dout}
//   1 CFG    write -> if_cmd, read -> {0, cfg_shadow} (no core access)
//   2 STATUS read -> {err_cnt, rx_empty_cnt}, write acked and ignored
//   3 -      any access -> wb_err_o
//
// Build option: WB_SPI_TIMEOUT_EN enables the core-ack timeout, the timeout
// error response and err_cnt. Without it the bus waits for if_ack forever.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   wb_cyc_i, wb_stb_i       bus cycle / strobe
//   wb_we_i, wb_adr_i        write enable, word address
//   wb_dat_i, wb_dat_o       write / read data (DW bits)
//   wb_ack_o, wb_err_o       transfer done / transfer failed
//   if_din                   11-bit word to the core
//   if_cmd, if_wr, if_rd     one-cycle core strobes
//   if_dout                  9-bit word from the core, bit 8 = rx empty
//   if_ack                   core ack, one cycle after the strobe

module wb_spi_slave #(
   parameter int DW      = 16,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wb_cyc_i,
   input  logic          wb_stb_i,
   input  logic          wb_we_i,
   input  logic [1:0]    wb_adr_i,
   input  logic [DW-1:0] wb_dat_i,
   output logic [DW-1:0] wb_dat_o,
   output logic          wb_ack_o,
   output logic          wb_err_o,
   output logic [10:0]   if_din,
   output logic          if_cmd,
   output logic          if_wr,
   output logic          if_rd,
   input  logic [8:0]    if_dout,
   input  logic          if_ack
);

   typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT, S_RESP} state_t;

   localparam logic [1:0] A_DATA   = 2'd0;
   localparam logic [1:0] A_CFG    = 2'd1;
   localparam logic [1:0] A_STATUS = 2'd2;
   localparam logic [1:0] A_BAD    = 2'd3;

   state_t        state, state_nx;
   logic [1:0]    adr_q;
   logic          we_q;
   logic [10:0]   dat_q;
   logic [DW-1:0] rdata;
   logic [10:0]   cfg_shadow;
   logic [7:0]    err_cnt;
   logic [7:0]    rx_empty_cnt;
   logic          abort_q;
   logic          fail_q;
   logic          req;
   logic          needs_core;
   logic          tmo_hit;

   // Only bits [10:0] of the write data carry meaning.
   logic unused_dat;
   assign unused_dat = ^wb_dat_i[DW-1:11];

   assign req        = wb_cyc_i & wb_stb_i;
   assign needs_core = (wb_adr_i == A_DATA) || ((wb_adr_i == A_CFG) && wb_we_i);

`ifdef WB_SPI_TIMEOUT_EN
   logic [15:0] tmo_cnt;

   // Held at zero outside WAIT, so it always starts from 0 on entry.
   always_ff @(posedge clk) begin
      if (rst || state != S_WAIT) tmo_cnt <= '0;
      else                        tmo_cnt <= tmo_cnt + 16'd1;
   end

   // WAIT lasts at most TIMEOUT cycles; an ack in the last one still wins.
   assign tmo_hit = (state == S_WAIT) && !if_ack && (tmo_cnt == 16'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst)                             err_cnt <= '0;
      else if (tmo_hit && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
   end
`else
   // TIMEOUT has no effect in this build.
   logic [15:0] unused_tmo;
   assign unused_tmo = 16'(TIMEOUT);
   assign tmo_hit    = 1'b0;
   assign err_cnt    = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         adr_q        <= '0;
         we_q         <= 1'b0;
         dat_q        <= '0;
         rdata        <= '0;
         cfg_shadow   <= '0;
         rx_empty_cnt <= '0;
         abort_q      <= 1'b0;
         fail_q       <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            S_IDLE: begin
               if (req) begin
                  adr_q   <= wb_adr_i;
                  we_q    <= wb_we_i;
                  dat_q   <= wb_dat_i[10:0];
                  abort_q <= 1'b0;
                  fail_q  <= (wb_adr_i == A_BAD);
                  // Register-only reads are answered from here; DATA reads
                  // overwrite rdata in STROBE.
                  if (!wb_we_i && wb_adr_i == A_CFG)
                     rdata <= DW'(cfg_shadow);
                  else if (!wb_we_i && wb_adr_i == A_STATUS)
                     rdata <= DW'({err_cnt, rx_empty_cnt});
                  else
                     rdata <= '0;
               end
            end
            S_STROBE: begin
               if (!wb_cyc_i) abort_q <= 1'b1;
               if (if_rd) begin
                  rdata <= DW'(if_dout);
                  if (if_dout[8] && rx_empty_cnt != 8'hFF)
                     rx_empty_cnt <= rx_empty_cnt + 8'd1;
               end
            end
            S_WAIT: begin
               if (!wb_cyc_i) abort_q <= 1'b1;
               // Shadow follows the core, so it only changes once the core
               // has accepted the config word (even if the bus gave up).
               if (if_ack) begin
                  if (adr_q == A_CFG) cfg_shadow <= dat_q;
               end else if (tmo_hit) begin
                  fail_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx = state;
      wb_ack_o = 1'b0;
      wb_err_o = 1'b0;
      wb_dat_o = '0;
      if_din   = '0;
      if_cmd   = 1'b0;
      if_wr    = 1'b0;
      if_rd    = 1'b0;
      case (state)
         S_IDLE: begin
            if (req) state_nx = needs_core ? S_STROBE : S_RESP;
         end
         S_STROBE: begin
            // Only DATA accesses and CFG writes reach this state.
            if_din   = dat_q;
            if_wr    = (adr_q == A_DATA) && we_q;
            if_rd    = (adr_q == A_DATA) && !we_q;
            if_cmd   = (adr_q == A_CFG);
            state_nx = S_WAIT;
         end
         S_WAIT: begin
            if (if_ack || tmo_hit) state_nx = S_RESP;
         end
         S_RESP: begin
            state_nx = S_IDLE;
            wb_dat_o = rdata;
            if (!abort_q) begin
               wb_ack_o = !fail_q;
               wb_err_o = fail_q;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_wb_spi_slave.sv
// tb/tb_wb_spi_slave.sv - self-checking bench for wb_spi_slave

module tb_wb_spi_slave;

   localparam int DW  = 16;
   localparam int TMO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wb_cyc_i = 1'b0;
   logic          wb_stb_i = 1'b0;
   logic          wb_we_i = 1'b0;
   logic [1:0]    wb_adr_i = '0;
   logic [DW-1:0] wb_dat_i = '0;
   logic [DW-1:0] wb_dat_o;
   logic          wb_ack_o;
   logic          wb_err_o;
   logic [10:0]   if_din;
   logic          if_cmd;
   logic          if_wr;
   logic          if_rd;
   logic [8:0]    core_dout = '0;
   logic          if_ack;

   logic ack_auto  = 1'b0;
   logic ack_force = 1'b0;
   bit   core_auto = 1'b1;
   assign if_ack = ack_auto | ack_force;

   wb_spi_slave #(.DW(DW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
      .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
      .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
      .if_din(if_din), .if_cmd(if_cmd), .if_wr(if_wr), .if_rd(if_rd),
      .if_dout(core_dout), .if_ack(if_ack)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference state: what software should read back.
   logic [10:0] m_cfg = '0;
   logic [7:0]  m_rx  = '0;
   logic [7:0]  m_err = '0;

   // Strobe log: {cmd, wr, rd, din}
   logic [13:0] strobes[$];
   int  viol = 0;
   bit  prev_any = 1'b0;
   bit  strobe_prev = 1'b0;
   int  nstb;

   always @(negedge clk) begin
      nstb = int'(if_cmd) + int'(if_wr) + int'(if_rd);
      if (nstb > 1 || (nstb > 0 && prev_any)) viol++;
      prev_any = (nstb > 0);
      if (nstb > 0) strobes.push_back({if_cmd, if_wr, if_rd, if_din});
      strobe_prev = (nstb > 0);
   end

   // Core model: acks one cycle after any strobe when enabled.
   always @(posedge clk) begin
      #1;
      ack_auto = core_auto && strobe_prev;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bus(input logic we, input logic [1:0] adr, input logic [15:0] dat,
                      output logic [15:0] rd, output logic ok, output logic er, output int lat);
      @(posedge clk); #1;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
      lat = -1; rd = '0; ok = 1'b0; er = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (wb_ack_o || wb_err_o) begin
            lat = i; ok = wb_ack_o; er = wb_err_o; rd = wb_dat_o;
            break;
         end
      end
      @(posedge clk); #1;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
   endtask

   // dout < 0 picks a random core word for DATA reads.
   task automatic xfer(input logic we, input logic [1:0] adr, input logic [15:0] dat,
                       input int dout, input bit tmo);
      logic [15:0] rd, exp_rd;
      logic ok, er;
      int lat, exp_lat;
      bit core, exp_err;
      logic [2:0] kind;
      core    = (adr == 2'd0) || (adr == 2'd1 && we);
      exp_err = (adr == 2'd3) || tmo;
      exp_lat = !core ? 1 : (tmo ? TMO + 2 : 3);
      kind    = (adr == 2'd0) ? (we ? 3'b010 : 3'b001) : 3'b100;
      exp_rd  = '0;
      if (adr == 2'd0 && !we) begin
         core_dout = (dout < 0) ? 9'($urandom) : 9'(dout);
         exp_rd = {7'd0, core_dout};
      end
      if (adr == 2'd1 && !we) exp_rd = {5'd0, m_cfg};
      if (adr == 2'd2 && !we) exp_rd = {m_err, m_rx};
      core_auto = !tmo;
      strobes.delete();
      bus(we, adr, dat, rd, ok, er, lat);
      chk($sformatf("outcome a%0d w%0d", adr, we), {30'd0, ok, er}, {30'd0, !exp_err, exp_err});
      chk($sformatf("latency a%0d w%0d", adr, we), lat, exp_lat);
      chk($sformatf("strobe_count a%0d w%0d", adr, we), strobes.size(), core);
      if (core && strobes.size() == 1) begin
         chk("strobe_kind", strobes[0][13:11], kind);
         if (we) chk("strobe_din", strobes[0][10:0], dat[10:0]);
      end
      if (!we && !exp_err) chk($sformatf("rdata a%0d", adr), rd, exp_rd);
      if (adr == 2'd0 && !we && core_dout[8] && m_rx != 8'hFF) m_rx++;
      if (adr == 2'd1 && we) m_cfg = dat[10:0];
      if (tmo && m_err != 8'hFF) m_err++;
      core_auto = 1'b1;
   endtask

   int seen;

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_outputs", {wb_ack_o, wb_err_o, wb_dat_o, if_cmd, if_wr, if_rd, if_din},
          32'd0);

      // Directed core accesses
      xfer(1'b1, 2'd1, 16'h00A5, 0, 1'b0);
      xfer(1'b0, 2'd1, 16'h0000, 0, 1'b0);
      xfer(1'b1, 2'd0, 16'h03C1, 0, 1'b0);
      xfer(1'b0, 2'd0, 16'h0000, 9'h05A, 1'b0);
      xfer(1'b0, 2'd0, 16'h0000, 9'h100, 1'b0);
      xfer(1'b0, 2'd2, 16'h0000, 0, 1'b0);

`ifdef WB_SPI_TIMEOUT_EN
      xfer(1'b1, 2'd0, 16'h0111, 0, 1'b1);
`else
      core_auto = 1'b0;
      strobes.delete();
      seen = 0;
      @(posedge clk); #1;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 2'd0; wb_dat_i = 16'h0155;
      repeat (40) begin
         @(negedge clk);
         if (wb_ack_o || wb_err_o) seen++;
      end
      chk("stall_no_resp", seen, 0);
      @(posedge clk); #1 ack_force = 1'b1;
      @(posedge clk); #1 ack_force = 1'b0;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (wb_ack_o) begin seen = 1; break; end
      end
      chk("stall_release_ack", seen, 1);
      @(posedge clk); #1 wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      chk("stall_strobes", strobes.size(), 1);
      core_auto = 1'b1;
`endif
      xfer(1'b0, 2'd2, 16'h0000, 0, 1'b0);

      // Abort a CFG write in WAIT; the late core ack still updates the shadow.
      core_auto = 1'b0;
      strobes.delete();
      @(posedge clk); #1;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 2'd1; wb_dat_i = 16'h0123;
      @(negedge clk);
      @(negedge clk);
      @(posedge clk); #1 wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      repeat (2) @(posedge clk);
      #1 ack_force = 1'b1;
      @(posedge clk); #1 ack_force = 1'b0;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (wb_ack_o || wb_err_o) seen++;
      end
      chk("abort_no_resp", seen, 0);
      chk("abort_strobes", strobes.size(), 1);
      m_cfg = 11'h123;
      core_auto = 1'b1;
      xfer(1'b0, 2'd1, 16'h0000, 0, 1'b0);

      // Invalid address, ignored STATUS write, stray ack while idle
      xfer(1'b0, 2'd3, 16'h0000, 0, 1'b0);
      xfer(1'b1, 2'd3, 16'h07FF, 0, 1'b0);
      xfer(1'b1, 2'd2, 16'hFFFF, 0, 1'b0);
      @(posedge clk); #1 ack_force = 1'b1;
      @(posedge clk); #1 ack_force = 1'b0;
      xfer(1'b0, 2'd2, 16'h0000, 0, 1'b0);

      // Random traffic
      for (int i = 0; i < 40; i++)
         xfer(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom), -1, 1'b0);

      // Drive rx_empty_cnt into saturation
      for (int i = 0; i < 258; i++) xfer(1'b0, 2'd0, 16'h0000, 9'h100, 1'b0);
      xfer(1'b0, 2'd2, 16'h0000, 0, 1'b0);

      // Reset while waiting on the core
      core_auto = 1'b0;
      @(posedge clk); #1;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 2'd0; wb_dat_i = 16'h0042;
      @(negedge clk);
      @(negedge clk);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_mid_outputs", {wb_ack_o, wb_err_o, wb_dat_o, if_cmd, if_wr, if_rd, if_din},
          32'd0);
      @(posedge clk); #1;
      rst = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      core_auto = 1'b1;
      m_cfg = '0; m_rx = '0; m_err = '0;
      xfer(1'b0, 2'd2, 16'h0000, 0, 1'b0);
      xfer(1'b0, 2'd1, 16'h0000, 0, 1'b0);

      @(negedge clk);
      chk("idle_dat_o", wb_dat_o, 32'd0);
      chk("strobe_rules", viol, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
